// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding, request bundle and word geometry.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_WAIT,
      MS_RESP
   } mem_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with one synchronous byte-enabled write port and one asynchronous read port.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [WORD_BYTES-1:0] i_wstrb,
   input  logic [AW-1:0]         i_idx,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   // NOTE: the storage array has no reset; clearing it would force a flop-based
   // implementation and contents must survive a reset of the control logic anyway.
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (i_we && i_wstrb[b]) begin
            r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory slave for the core's request/response handshake: decode, store commit at accept,
// configurable response latency and a registered, non-retracting response.
module mem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   input  logic [3:0]  REQ_WSTRB,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);
   localparam logic [3:0]  LAT_INIT  = 4'(LATENCY - 1);

   mem_state_t  r_state;
   mem_state_t  w_state_nxt;
   logic [3:0]  r_cnt;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;

   mem_req_t    w_req;
   logic [31:0] w_off;
   logic [AW-1:0] w_idx;
   logic        w_err;
   logic        w_accept;
   logic        w_wr_en;
   logic [31:0] w_mem_rdata;

   assign w_req = '{we: REQ_WE, addr: REQ_ADDR, wdata: REQ_WDATA, wstrb: REQ_WSTRB};

   // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
   assign w_off    = w_req.addr - BASE_ADDR;
   assign w_idx    = w_off[AW+1:2];
   assign w_err    = (w_req.addr[1:0] != 2'b00) || (w_off >= MEM_BYTES);
   assign w_accept = REQ_VALID && REQ_READY;
   assign w_wr_en  = w_accept && w_req.we && !w_err;

   assign REQ_READY = (r_state == MS_IDLE);

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .i_clk   (CLK),
      .i_we    (w_wr_en),
      .i_wstrb (w_req.wstrb),
      .i_idx   (w_idx),
      .i_wdata (w_req.wdata),
      .o_rdata (w_mem_rdata)
   );

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MS_IDLE: if (REQ_VALID) w_state_nxt = (LATENCY > 1) ? MS_WAIT : MS_RESP;
         MS_WAIT: if (r_cnt <= 4'd1) w_state_nxt = MS_RESP;
         MS_RESP: if (RSP_READY) w_state_nxt = MS_IDLE;
         default: w_state_nxt = MS_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= MS_IDLE;
         r_cnt       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= (w_state_nxt == MS_RESP);
         if (w_accept) begin
            r_cnt       <= LAT_INIT;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || w_req.we) ? 32'd0 : w_mem_rdata;
         end else if (r_state == MS_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign RSP_VALID = r_rsp_valid;
   assign RSP_RDATA = r_rsp_rdata;
   assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus random bench for mem_responder: two instances (LATENCY 1 / base 0 and
// LATENCY 3 / base 0x100) checked against a model memory and an expected-response queue.
module tb_mem_responder;

   localparam int          DW    = 64;
   localparam int          IW    = $clog2(DW);
   localparam logic [31:0] BASE1 = 32'h100;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   logic [31:0] mdl [2][DW];
   exp_t        sb [$];
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut0 (
      .CLK       (clk),
      .RST       (rst),
      .REQ_VALID (req_valid[0]),
      .REQ_READY (req_ready[0]),
      .REQ_WE    (req_we[0]),
      .REQ_ADDR  (req_addr[0]),
      .REQ_WDATA (req_wdata[0]),
      .REQ_WSTRB (req_wstrb[0]),
      .RSP_VALID (rsp_valid[0]),
      .RSP_READY (rsp_ready[0]),
      .RSP_RDATA (rsp_rdata[0]),
      .RSP_ERR   (rsp_err[0])
   );

   mem_responder #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(BASE1)) u_dut1 (
      .CLK       (clk),
      .RST       (rst),
      .REQ_VALID (req_valid[1]),
      .REQ_READY (req_ready[1]),
      .REQ_WE    (req_we[1]),
      .REQ_ADDR  (req_addr[1]),
      .REQ_WDATA (req_wdata[1]),
      .REQ_WSTRB (req_wstrb[1]),
      .RSP_VALID (rsp_valid[1]),
      .RSP_READY (rsp_ready[1]),
      .RSP_RDATA (rsp_rdata[1]),
      .RSP_ERR   (rsp_err[1])
   );

   function automatic logic [31:0] base_of(int s);
      return (s == 0) ? 32'h0 : BASE1;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request at a negedge, waits for acceptance, updates the model and
   // queues the expected response. Returns 1ns after the accepting edge.
   task automatic send(int s, logic we, logic [31:0] off, logic [31:0] wdata,
                       logic [3:0] wstrb, string tag);
      logic [31:0] addr;
      logic [31:0] o;
      exp_t        e;
      int          n;
      addr = base_of(s) + off;
      @(negedge clk);
      req_valid[s] = 1'b1;
      req_we[s]    = we;
      req_addr[s]  = addr;
      req_wdata[s] = wdata;
      req_wstrb[s] = wstrb;
      n = 0;
      while (req_ready[s] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " req_ready"}, 32'(req_ready[s]), 32'd1);
      o       = addr - base_of(s);
      e.err   = (addr[1:0] != 2'b00) || (o >= 32'(DW * 4));
      e.rdata = (e.err || we) ? 32'd0 : mdl[s][o[IW+1:2]];
      if (we && !e.err) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mdl[s][o[IW+1:2]][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid[s] = 1'b0;
   endtask

   // Waits for the response (optionally with random RSP_READY), compares it against the
   // queue head and checks that RSP_VALID falls right after the handshake.
   task automatic recv(int s, string tag, bit rand_ready);
      exp_t e;
      int   n;
      n = 0;
      do begin
         @(negedge clk);
         rsp_ready[s] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         n++;
      end while (!(rsp_valid[s] === 1'b1 && rsp_ready[s]) && n < 100);
      e = sb.pop_front();
      check({tag, " rsp_valid"}, 32'(rsp_valid[s]), 32'd1);
      check({tag, " rdata"}, rsp_rdata[s], e.rdata);
      check({tag, " err"}, 32'(rsp_err[s]), 32'(e.err));
      @(posedge clk);
      #1;
      rsp_ready[s] = 1'b0;
      check({tag, " valid drop"}, 32'(rsp_valid[s]), 32'd0);
   endtask

   task automatic txn(int s, logic we, logic [31:0] off, logic [31:0] wdata,
                      logic [3:0] wstrb, string tag);
      send(s, we, off, wdata, wstrb, tag);
      recv(s, tag, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0;
         req_we[s]    = 1'b0;
         req_addr[s]  = 32'd0;
         req_wdata[s] = 32'd0;
         req_wstrb[s] = 4'd0;
         rsp_ready[s] = 1'b0;
      end

      // Reset state of both instances.
      #12;
      for (int s = 0; s < 2; s++) begin
         check("reset req_ready", 32'(req_ready[s]), 32'd1);
         check("reset rsp_valid", 32'(rsp_valid[s]), 32'd0);
         check("reset rsp_rdata", rsp_rdata[s], 32'd0);
         check("reset rsp_err", 32'(rsp_err[s]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // LATENCY=1: response is already registered when the next edge samples it.
      send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
      check("lat1 rsp_valid", 32'(rsp_valid[0]), 32'd1);
      check("lat1 req_ready", 32'(req_ready[0]), 32'd0);
      recv(0, "st10", 1'b0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10");

      // Byte lanes and strobe-free store.
      txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "st20");
      txn(0, 1'b1, 32'h20, 32'h000000AA, 4'h1, "st20b0");
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "ld20");
      txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "st20none");
      txn(0, 1'b1, 32'h20, 32'h5500CC00, 4'hA, "st20hi");
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "ld20b");

      // Error responses; memory unchanged.
      txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, "st0");
      txn(0, 1'b0, 32'h22, 32'h0, 4'h0, "ld22mis");
      txn(0, 1'b1, 32'(DW * 4), 32'h12345678, 4'hF, "stoor");
      txn(0, 1'b1, 32'h1, 32'h12345678, 4'hF, "st1mis");
      txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "ld0");
      txn(1, 1'b1, 32'(DW * 4 - 4), 32'hA5A5_5A5A, 4'hF, "b1last");
      txn(1, 1'b0, 32'(DW * 4 - 4), 32'h0, 4'h0, "b1ldlast");
      txn(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, "b1below");
      txn(1, 1'b0, 32'(DW * 4), 32'h0, 4'h0, "b1oor");

      // LATENCY=3 with backpressure. The negedge before edge T+n shows what edge T+n samples.
      txn(1, 1'b1, 32'h8, 32'h600D_CAFE, 4'hF, "b1st8");
      send(1, 1'b0, 32'h8, 32'h0, 4'h0, "bp");
      @(negedge clk);
      check("bp lat edge1", 32'(rsp_valid[1]), 32'd0);
      @(negedge clk);
      check("bp lat edge2", 32'(rsp_valid[1]), 32'd0);
      @(negedge clk);
      check("bp lat edge3", 32'(rsp_valid[1]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp hold valid", 32'(rsp_valid[1]), 32'd1);
         check("bp hold rdata", rsp_rdata[1], sb[0].rdata);
         check("bp hold err", 32'(rsp_err[1]), 32'(sb[0].err));
         check("bp hold req_ready", 32'(req_ready[1]), 32'd0);
      end
      @(negedge clk);
      rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[1] = 1'b0;
      e = sb.pop_front();
      check("bp release valid", 32'(rsp_valid[1]), 32'd0);
      check("bp release req_ready", 32'(req_ready[1]), 32'd1);

      // Reset while waiting on an accepted store: response dropped, store kept.
      send(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, "rststore");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst rsp_valid", 32'(rsp_valid[1]), 32'd0);
      check("midrst req_ready", 32'(req_ready[1]), 32'd1);
      e = sb.pop_front();
      @(negedge clk);
      rst = 1'b0;
      txn(1, 1'b0, 32'h30, 32'h0, 4'h0, "ldafterrst");

      // Back-to-back random traffic with random RSP_READY.
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 16; w++) begin
            send(s, 1'b1, 32'(w * 4), 32'($urandom), 4'hF, "init");
            recv(s, "init", 1'b1);
         end
         for (int i = 0; i < 40; i++) begin
            logic [31:0] off;
            off = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) off = off + 32'($urandom_range(1, 3));
            send(s, 1'($urandom_range(0, 1)), off, 32'($urandom), 4'($urandom_range(0, 15)), "rnd");
            recv(s, "rnd", 1'b1);
         end
      end
      check("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
